// File: rtl/soul_controller.sv
// soul_controller
// Executes the game state machine's 16-bit player instruction word
// {op[15:12], arg[11:8], val[7:0]} on the player soul. It keeps the soul
// position inside the dodge box, the player HP and the IDLE/ACTIVE/DEAD state.
// One-shot opcodes fire on the cycle the instruction word changes. MOV is
// level-sensitive: it steps on the change cycle, then every STEP_DIV cycles.
// Optional feature macro: SOUL_INVULN_EN adds an invulnerability window of
// INVULN_CYCLES clocks after any damage that actually lowers HP.
module soul_controller #(
  parameter int X_MIN    = 240,
  parameter int X_MAX    = 400,
  parameter int Y_MIN    = 240,
  parameter int Y_MAX    = 400,
  parameter int STEP     = 2,
  parameter int STEP_DIV = 1000000,
  parameter int MAX_HP   = 20
`ifdef SOUL_INVULN_EN
  ,
  parameter int INVULN_CYCLES = 50000000
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] player_instruction,
  output logic [9:0]  soul_x,
  output logic [9:0]  soul_y,
  output logic [7:0]  player_hp,
  output logic        is_death,
  output logic        is_active
);

  localparam logic [9:0] X_CTR = 10'((X_MIN + X_MAX) / 2);
  localparam logic [9:0] Y_CTR = 10'((Y_MIN + Y_MAX) / 2);
  localparam int         CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

  localparam logic [3:0] OP_HPY = 4'd1;
  localparam logic [3:0] OP_DPY = 4'd2;
  localparam logic [3:0] OP_IDG = 4'd3;
  localparam logic [3:0] OP_SDG = 4'd4;
  localparam logic [3:0] OP_MOV = 4'd5;
  localparam logic [3:0] OP_SHP = 4'd6;

  localparam logic [3:0] DIR_UP    = 4'd0;
  localparam logic [3:0] DIR_RIGHT = 4'd1;
  localparam logic [3:0] DIR_DOWN  = 4'd2;
  localparam logic [3:0] DIR_LEFT  = 4'd3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DEAD   = 2'd2
  } state_t;

  state_t           r_state;
  logic [15:0]      r_prev_instr;
  logic [9:0]       r_x;
  logic [9:0]       r_y;
  logic [7:0]       r_hp;
  logic [CNT_W-1:0] r_step_cnt;

  state_t           w_next_state;
  logic [9:0]       w_next_x;
  logic [9:0]       w_next_y;
  logic [7:0]       w_next_hp;
  logic [CNT_W-1:0] w_next_cnt;

  logic [3:0]       w_op;
  logic [3:0]       w_arg;
  logic [7:0]       w_val;
  logic             w_changed;
  logic             w_is_mov;
  logic             w_step_now;
  logic             w_dpy_ok;

  logic [9:0]       w_up_y;
  logic [9:0]       w_down_y;
  logic [9:0]       w_left_x;
  logic [9:0]       w_right_x;
  logic [8:0]       w_hp_sum;
  logic [7:0]       w_heal_hp;
  logic [7:0]       w_dmg_hp;
  logic [7:0]       w_set_hp;

`ifdef SOUL_INVULN_EN
  localparam int INV_W = $clog2(INVULN_CYCLES + 1);
  logic [INV_W-1:0] r_inv_cnt;
  logic [INV_W-1:0] w_next_inv;
`endif

  assign w_op      = player_instruction[15:12];
  assign w_arg     = player_instruction[11:8];
  assign w_val     = player_instruction[7:0];
  assign w_changed = (player_instruction != r_prev_instr);

  // A MOV with an undefined direction behaves like any other NOP word
  assign w_is_mov   = (w_op == OP_MOV) && (w_arg <= DIR_LEFT);
  assign w_step_now = w_is_mov && (w_changed || (r_step_cnt == CNT_LAST));

  assign soul_x    = r_x;
  assign soul_y    = r_y;
  assign player_hp = r_hp;
  assign is_death  = (r_state == S_DEAD);
  assign is_active = (r_state == S_ACTIVE);

`ifdef SOUL_INVULN_EN
  assign w_dpy_ok = (r_inv_cnt == '0);
`else
  assign w_dpy_ok = 1'b1;
`endif

  // Candidate positions one step in each direction, clamped to the box in 11 bits
  always_comb begin
    w_up_y    = ({1'b0, r_y} < 11'(Y_MIN + STEP)) ? 10'(Y_MIN) : (r_y - 10'(STEP));
    w_down_y  = (({1'b0, r_y} + 11'(STEP)) > 11'(Y_MAX)) ? 10'(Y_MAX) : (r_y + 10'(STEP));
    w_left_x  = ({1'b0, r_x} < 11'(X_MIN + STEP)) ? 10'(X_MIN) : (r_x - 10'(STEP));
    w_right_x = (({1'b0, r_x} + 11'(STEP)) > 11'(X_MAX)) ? 10'(X_MAX) : (r_x + 10'(STEP));
  end

  // Candidate HP values for heal, damage and set, saturating at 0 and MAX_HP
  always_comb begin
    w_hp_sum  = {1'b0, r_hp} + {1'b0, w_val};
    w_heal_hp = (w_hp_sum > 9'(MAX_HP)) ? 8'(MAX_HP) : w_hp_sum[7:0];
    w_dmg_hp  = (w_val >= r_hp) ? 8'd0 : (r_hp - w_val);
    w_set_hp  = ({1'b0, w_val} > 9'(MAX_HP)) ? 8'(MAX_HP) : w_val;
  end

  // Next-state and datapath decode; every target holds its value unless an opcode acts
  always_comb begin
    w_next_state = r_state;
    w_next_x     = r_x;
    w_next_y     = r_y;
    w_next_hp    = r_hp;
    w_next_cnt   = (!w_is_mov || w_changed || w_step_now) ? '0 : (r_step_cnt + 1'b1);
`ifdef SOUL_INVULN_EN
    w_next_inv   = (r_inv_cnt != '0) ? (r_inv_cnt - 1'b1) : '0;
`endif

    if (w_changed && (w_op == OP_IDG)) begin
      w_next_state = S_IDLE;
      w_next_x     = X_CTR;
      w_next_y     = Y_CTR;
      w_next_cnt   = '0;
`ifdef SOUL_INVULN_EN
      w_next_inv   = '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_changed) begin
            case (w_op)
              OP_SDG: w_next_state = S_ACTIVE;
              OP_HPY: w_next_hp = w_heal_hp;
              OP_SHP: begin
                w_next_hp = w_set_hp;
`ifdef SOUL_INVULN_EN
                w_next_inv = '0;
`endif
              end
              default: ;
            endcase
          end
        end

        S_ACTIVE: begin
          if (w_changed) begin
            case (w_op)
              OP_HPY: w_next_hp = w_heal_hp;
              OP_SHP: begin
                w_next_hp = w_set_hp;
                if (w_set_hp == 8'd0) w_next_state = S_DEAD;
`ifdef SOUL_INVULN_EN
                w_next_inv = '0;
`endif
              end
              OP_DPY: begin
                if (w_dpy_ok) begin
                  w_next_hp = w_dmg_hp;
                  if (w_dmg_hp == 8'd0) w_next_state = S_DEAD;
`ifdef SOUL_INVULN_EN
                  if (w_dmg_hp != r_hp) w_next_inv = INV_W'(INVULN_CYCLES);
`endif
                end
              end
              default: ;
            endcase
          end
          if (w_step_now) begin
            case (w_arg)
              DIR_UP:    w_next_y = w_up_y;
              DIR_RIGHT: w_next_x = w_right_x;
              DIR_DOWN:  w_next_y = w_down_y;
              DIR_LEFT:  w_next_x = w_left_x;
              default: ;
            endcase
          end
        end

        S_DEAD: begin
          if (w_changed && (w_op == OP_SHP)) begin
            w_next_hp = w_set_hp;
            if (w_val != 8'd0) w_next_state = S_IDLE;
`ifdef SOUL_INVULN_EN
            w_next_inv = '0;
`endif
          end
        end

        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // State register and all soul/HP registers, cleared at once by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_prev_instr <= 16'd0;
      r_x          <= X_CTR;
      r_y          <= Y_CTR;
      r_hp         <= 8'(MAX_HP);
      r_step_cnt   <= '0;
    end else begin
      r_state      <= w_next_state;
      r_prev_instr <= player_instruction;
      r_x          <= w_next_x;
      r_y          <= w_next_y;
      r_hp         <= w_next_hp;
      r_step_cnt   <= w_next_cnt;
    end
  end

`ifdef SOUL_INVULN_EN
  // Invulnerability countdown, loaded by damage and cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inv_cnt <= '0;
    end else begin
      r_inv_cnt <= w_next_inv;
    end
  end
`endif

endmodule

// File: tb/tb_soul_controller.sv
// tb_soul_controller
// Directed checks of soul_controller with STEP_DIV=4 so held-MOV timing is short.
// The SOUL_INVULN_EN section runs only when that macro is defined.
module tb_soul_controller;

  logic        clk;
  logic        rst_n;
  logic [15:0] player_instruction;
  logic [9:0]  soul_x;
  logic [9:0]  soul_y;
  logic [7:0]  player_hp;
  logic        is_death;
  logic        is_active;

  int total = 0;
  int bad   = 0;

  soul_controller #(
    .X_MIN(240), .X_MAX(400), .Y_MIN(240), .Y_MAX(400),
    .STEP(2), .STEP_DIV(4), .MAX_HP(20)
`ifdef SOUL_INVULN_EN
    , .INVULN_CYCLES(8)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .player_instruction(player_instruction),
    .soul_x(soul_x),
    .soul_y(soul_y),
    .player_hp(player_hp),
    .is_death(is_death),
    .is_active(is_active)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive a word, let n rising edges pass, then settle 1 ns past the last edge
  task automatic applyStimulus(input logic [15:0] word, input int n);
    player_instruction = word;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Directed sequence with hand-computed expectations
  initial begin
    rst_n = 1'b0;
    player_instruction = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    checkOutput("rst_x", 16'(soul_x), 16'd320);
    checkOutput("rst_y", 16'(soul_y), 16'd320);
    checkOutput("rst_hp", 16'(player_hp), 16'd20);
    checkOutput("rst_death", 16'(is_death), 16'd0);
    checkOutput("rst_active", 16'(is_active), 16'd0);

    applyStimulus(16'h5000, 2);
    checkOutput("idle_mov_y", 16'(soul_y), 16'd320);

    applyStimulus(16'h4000, 1);
    checkOutput("sdg_active", 16'(is_active), 16'd1);

    applyStimulus(16'h5100, 1);
    checkOutput("mov_r_c1", 16'(soul_x), 16'd322);
    applyStimulus(16'h5100, 3);
    checkOutput("mov_r_c4", 16'(soul_x), 16'd322);
    applyStimulus(16'h5100, 1);
    checkOutput("mov_r_c5", 16'(soul_x), 16'd324);
    applyStimulus(16'h5100, 3);
    checkOutput("mov_r_c8", 16'(soul_x), 16'd324);
    applyStimulus(16'h5100, 1);
    checkOutput("mov_r_c9", 16'(soul_x), 16'd326);

    applyStimulus(16'h5000, 153);
    checkOutput("mov_up_242", 16'(soul_y), 16'd242);
    applyStimulus(16'h5000, 4);
    checkOutput("mov_up_240", 16'(soul_y), 16'd240);
    applyStimulus(16'h5000, 8);
    checkOutput("mov_up_hold", 16'(soul_y), 16'd240);

    applyStimulus(16'h5200, 330);
    checkOutput("mov_down_400", 16'(soul_y), 16'd400);

    applyStimulus(16'h5300, 200);
    checkOutput("mov_left_240", 16'(soul_x), 16'd240);

    applyStimulus(16'h5400, 6);
    checkOutput("mov_bad_arg_x", 16'(soul_x), 16'd240);
    checkOutput("mov_bad_arg_y", 16'(soul_y), 16'd400);

    applyStimulus(16'h2005, 10);
    checkOutput("dpy_once", 16'(player_hp), 16'd15);

    applyStimulus(16'h0000, 1);
    applyStimulus(16'h2014, 1);
    checkOutput("dpy_kill_hp", 16'(player_hp), 16'd0);
    checkOutput("dpy_kill_death", 16'(is_death), 16'd1);
    checkOutput("dpy_kill_active", 16'(is_active), 16'd0);

    applyStimulus(16'h5100, 5);
    checkOutput("dead_mov_x", 16'(soul_x), 16'd240);
    applyStimulus(16'h1005, 1);
    checkOutput("dead_hpy", 16'(player_hp), 16'd0);

    applyStimulus(16'h6000, 1);
    checkOutput("shp0_death", 16'(is_death), 16'd1);
    applyStimulus(16'h6063, 1);
    checkOutput("shp99_hp", 16'(player_hp), 16'd20);
    checkOutput("shp99_death", 16'(is_death), 16'd0);
    checkOutput("shp99_active", 16'(is_active), 16'd0);

    applyStimulus(16'h3000, 1);
    checkOutput("idg_x", 16'(soul_x), 16'd320);
    checkOutput("idg_y", 16'(soul_y), 16'd320);

    applyStimulus(16'h2005, 1);
    checkOutput("idle_dpy", 16'(player_hp), 16'd20);
    applyStimulus(16'h6012, 1);
    checkOutput("shp18", 16'(player_hp), 16'd18);
    applyStimulus(16'h1005, 1);
    checkOutput("hpy_clamp", 16'(player_hp), 16'd20);

    applyStimulus(16'h4000, 1);
    applyStimulus(16'h6005, 1);
    checkOutput("shp5", 16'(player_hp), 16'd5);
    applyStimulus(16'h2005, 1);
    checkOutput("dpy_eq_hp", 16'(player_hp), 16'd0);
    checkOutput("dpy_eq_death", 16'(is_death), 16'd1);

    applyStimulus(16'h3000, 1);
    applyStimulus(16'h6014, 1);
    applyStimulus(16'h4000, 1);
    applyStimulus(16'h5100, 2);
    checkOutput("pre_rst_x", 16'(soul_x), 16'd322);
    rst_n = 1'b0;
    #2;
    checkOutput("midrst_x", 16'(soul_x), 16'd320);
    checkOutput("midrst_hp", 16'(player_hp), 16'd20);
    checkOutput("midrst_active", 16'(is_active), 16'd0);
    player_instruction = 16'h0000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(16'h0000, 5);
    checkOutput("postrst_x", 16'(soul_x), 16'd320);

`ifdef SOUL_INVULN_EN
    applyStimulus(16'h4000, 1);
    applyStimulus(16'h2003, 1);
    checkOutput("inv_first", 16'(player_hp), 16'd17);
    applyStimulus(16'h0000, 1);
    applyStimulus(16'h2003, 1);
    checkOutput("inv_blocked", 16'(player_hp), 16'd17);
    applyStimulus(16'h0000, 12);
    applyStimulus(16'h2003, 1);
    checkOutput("inv_expired", 16'(player_hp), 16'd14);
    applyStimulus(16'h0000, 2);
    rst_n = 1'b0;
    #2;
    checkOutput("inv_rst_hp", 16'(player_hp), 16'd20);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(16'h4000, 1);
    applyStimulus(16'h2003, 1);
    checkOutput("inv_rst_cleared", 16'(player_hp), 16'd17);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/soul_controller.md
Name: soul_controller

Overview:
- Downstream of the game state machine: consumes its 16-bit player instruction word and executes it on the player soul.
- Holds the soul position inside the dodge box, player HP and the death flag.
- is_death feeds the state machine's isDeath input; soul_x/soul_y feed the renderer.

Parameters:
X_MIN, 240, left box bound (pixels)
X_MAX, 400, right box bound
Y_MIN, 240, top box bound
Y_MAX, 400, bottom box bound
STEP, 2, pixels moved per step
STEP_DIV, 1000000, clk cycles between repeated steps while MOV is held
MAX_HP, 20, HP ceiling and reset HP
INVULN_CYCLES, 50000000, invulnerability window after damage (optional feature only)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
player_instruction  input  16  {op[15:12], arg[11:8], val[7:0]}; level-held by upstream
soul_x  output  10  soul x position
soul_y  output  10  soul y position
player_hp  output  8  current HP
is_death  output  1  high while in DEAD
is_active  output  1  high while in ACTIVE

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (rst_n). All outputs registered.
- Reset values: soul_x=(X_MIN+X_MAX)/2, soul_y=(Y_MIN+Y_MAX)/2, player_hp=MAX_HP, is_death=0, is_active=0, state IDLE, prev_instr=0, step counter=0.
- Opcodes:
  - 1 HPY: heal by val, saturate at MAX_HP.
  - 2 DPY: damage by val, floor at 0.
  - 3 IDG: init dodge.
  - 4 SDG: start dodge.
  - 5 MOV: move; arg = direction, 0 UP, 1 RIGHT, 2 DOWN, 3 LEFT.
  - 6 SHP: set hp = min(val, MAX_HP).
  - 0 and 7-15: NOP.
- Edge detection: prev_instr registers player_instruction every cycle. One-shot ops (HPY, DPY, IDG, SDG, SHP) execute only in the cycle where player_instruction != prev_instr. A held word executes once.
- MOV is level-sensitive:
  - First step on the change cycle, then one step every STEP_DIV cycles while the same MOV word is held.
  - Step counter clears whenever the word changes or is not MOV.
  - MOV with arg 4-15: NOP.
- States:
  - IDLE: MOV and DPY ignored. SDG -> ACTIVE.
  - ACTIVE: MOV moves, DPY damages. hp reaching 0 -> DEAD in the same update.
  - DEAD: MOV, DPY and HPY ignored. SHP with val>0 -> IDLE. SHP 0 stays DEAD.
  - In any state: IDG recentres soul, clears step counter, -> IDLE; HP unchanged.
- Clamping (no wrap):
  - UP: soul_y < Y_MIN+STEP -> Y_MIN, else soul_y-STEP.
  - DOWN: soul_y+STEP > Y_MAX -> Y_MAX.
  - LEFT and RIGHT analogous on x.
  - Compare in 11-bit arithmetic to avoid underflow.
- HP arithmetic:
  - 9-bit intermediate.
  - DPY val >= hp -> hp=0.
  - HPY hp+val > MAX_HP -> MAX_HP.
- Latency: outputs reflect an instruction one clk after it appears.
- is_death and is_active are decoded from the registered state.
- Reset mid-step or mid-invulnerability: all state cleared immediately, no pending step survives.

Optional Feature:
- Macro: SOUL_INVULN_EN.
- Defined:
  - A DPY that changes hp loads an invuln counter with INVULN_CYCLES.
  - While the counter is nonzero, DPY is ignored; the counter decrements each clk.
  - IDG and SHP clear the counter.
- Undefined: no counter; every DPY edge in ACTIVE applies.

Test Plan (STEP_DIV=4, STEP=2, MAX_HP=20, INVULN_CYCLES=8):
- Release rst_n -> soul (320,320), hp 20, is_death 0, is_active 0. MOV UP (0x5000) in IDLE -> position unchanged.
- SDG (0x4000), then hold MOV RIGHT (0x5100) for 9 cycles -> soul_x 322 after 1 clk, 324 at cycle 5, 326 at cycle 9.
- ACTIVE, soul_y=242, hold MOV UP -> soul_y 240 and stays 240; hold MOV DOWN to bound -> stays 400.
- ACTIVE, DPY 0x2005 held 10 cycles -> hp 15 once. Then NOP, DPY 0x2014 -> hp 0, is_death 1, is_active 0. Then MOV -> no movement.
- DEAD: SHP 0x6000 -> still DEAD. SHP 0x6063 -> hp 20 (clamped), IDLE. IDG -> (320,320). HPY 0x1005 at hp 18 -> hp 20.
- SOUL_INVULN_EN: DPY 0x2003, NOP, DPY 0x2003 within 8 cycles -> hp 17. Same after 8 cycles -> hp 14. Assert rst_n low mid-window -> hp 20, counter 0.
